// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, status and memory-side signals for the data memory arbiter.
// The arbiter takes the slave modport; requesters plus the memory model take master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_i;
    logic              we0_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] rdata0_o;
    logic              ack0_o;

    logic              req1_i;
    logic              we1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic              ack1_o;

    logic              busy_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [DATA_W-1:0] mem_data_i;

    modport master (
        output req0_i, we0_i, addr0_i, wdata0_i,
        output req1_i, we1_i, addr1_i, wdata1_i,
        output mem_data_i,
        input  rdata0_o, ack0_o, rdata1_o, ack1_o,
        input  busy_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
    );

    modport slave (
        input  req0_i, we0_i, addr0_i, wdata0_i,
        input  req1_i, we1_i, addr1_i, wdata1_i,
        input  mem_data_i,
        output rdata0_o, ack0_o, rdata1_o, ack1_o,
        output busy_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data memory: one fixed-length
// strobe per grant, read data captured on the last strobe edge, one-cycle ack.
module dmem_arbiter #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              pick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        pick     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_i || bus.req1_i) begin
                    // On a tie the port that did not win last time goes first.
                    pick    = (bus.req0_i && bus.req1_i) ? ~last_q : bus.req1_i;
                    win_d   = pick;
                    last_d  = pick;
                    we_d    = pick ? bus.we1_i    : bus.we0_i;
                    addr_d  = pick ? bus.addr1_i  : bus.addr0_i;
                    wdata_d = pick ? bus.wdata1_i : bus.wdata0_i;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (win_q) rdata1_d = bus.mem_data_i;
                        else       rdata0_d = bus.mem_data_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and memory bus are decoded from registered state so reset clears them at once.
    logic in_busy;
    assign in_busy         = (state_q == BUSY);
    assign bus.mem_read_o  = in_busy & ~we_q;
    assign bus.mem_write_o = in_busy & we_q;
    assign bus.mem_addr_o  = in_busy ? addr_q  : '0;
    assign bus.mem_data_o  = in_busy ? wdata_q : '0;
    assign bus.ack0_o      = (state_q == RESP) & ~win_q;
    assign bus.ack1_o      = (state_q == RESP) & win_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.rdata0_o    = rdata0_q;
    assign bus.rdata1_o    = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a per-cycle vector table, then a transaction-level
// reference model driven with random, contention, streaming and reset stimulus.
module tb_dmem_arbiter;
    localparam int L  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Device memory, written from whatever the DUT strobes onto the bus.
    logic [DW-1:0] mem [16];
    assign bus.mem_data_i = mem[bus.mem_addr_o[5:2]];

    // Reference model state: one outstanding transaction described by its grant cycle.
    int            t, s, free_from;
    bit            act;
    logic          mp, mwe, last;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic [DW-1:0] q [2];
    logic [DW-1:0] mmem [16];

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [4:0]    ctl;   // {mem_read, mem_write, ack0, ack1, busy}
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, q0, q1;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic [4:0] ctl, input logic [AW-1:0] ea,
                                input logic [DW-1:0] ed, q0, q1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.ctl = ctl; v.ea = ea; v.ed = ed; v.q0 = q0; v.q1 = q1;
        return v;
    endfunction

    function automatic logic [4:0] ctl_now();
        return {bus.mem_read_o, bus.mem_write_o, bus.ack0_o, bus.ack1_o, bus.busy_o};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0d actual=%h expected=%h", nm, t, act_v, exp_v);
        end
    endtask

    task automatic drive(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.req0_i = r0; bus.we0_i = w0; bus.addr0_i = a0; bus.wdata0_i = d0;
        bus.req1_i = r1; bus.we1_i = w1; bus.addr1_i = a1; bus.wdata1_i = d1;
    endtask

    task automatic capture_write();
        if (bus.mem_write_o) mem[bus.mem_addr_o[5:2]] = bus.mem_data_o;
    endtask

    task automatic model_init();
        act = 0; free_from = t; last = 1'b1;
        q[0] = '0; q[1] = '0;
    endtask

    // Asserts reset from a negedge, checks the cleared outputs, releases on a later negedge.
    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("rst_ctl", 64'(ctl_now()), 64'd0);
        chk("rst_rdata0", 64'(bus.rdata0_o), 64'd0);
        chk("rst_rdata1", 64'(bus.rdata1_o), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("rst_mem_data", 64'(bus.mem_data_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0 random, 1 both requesting, 2 port 0 streaming with port 1 raised at raise_at, 3 idle
    task automatic run_model(input int mode, input int n, input int raise_at);
        for (int i = 0; i < n; i++) begin
            logic [4:0]    ectl;
            logic          r0, r1, w0, w1;
            logic [AW-1:0] a0, a1;
            logic [DW-1:0] d0, d1;
            ectl = 5'b0;
            if (act && t >= s + 1 && t <= s + L) ectl = {~mwe, mwe, 1'b0, 1'b0, 1'b1};
            if (act && t == s + L + 1) begin
                ectl = {2'b00, ~mp, mp, 1'b1};
                if (mwe) mmem[maddr[5:2]] = mwd;
                else     q[mp] = mmem[maddr[5:2]];
            end
            chk("m_ctl", 64'(ctl_now()), 64'(ectl));
            chk("m_rdata0", 64'(bus.rdata0_o), 64'(q[0]));
            chk("m_rdata1", 64'(bus.rdata1_o), 64'(q[1]));
            if (ectl[4] | ectl[3]) begin
                chk("m_mem_addr", 64'(bus.mem_addr_o), 64'(maddr));
                chk("m_mem_data", 64'(bus.mem_data_o), 64'(mwd));
            end
            capture_write();

            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            a0 = AW'($urandom_range(0, 63)); a1 = AW'($urandom_range(0, 63));
            d0 = DW'($urandom); d1 = DW'($urandom);
            case (mode)
                0:       begin r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1)); end
                1:       begin r0 = 1'b1; r1 = 1'b1; end
                2:       begin r0 = 1'b1; r1 = (i >= raise_at); end
                default: begin r0 = 1'b0; r1 = 1'b0; end
            endcase
            drive(r0, w0, a0, d0, r1, w1, a1, d1);

            // Grant decision at the edge that ends this cycle.
            if (t >= free_from && (r0 || r1)) begin
                if (r0 && r1) mp = (last == 1'b0);
                else          mp = r1;
                last = mp; act = 1; s = t; free_from = t + L + 2;
                mwe   = mp ? w1 : w0;
                maddr = mp ? a1 : a0;
                mwd   = mp ? d1 : d0;
            end
            t++;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 32'h000000A5;
            mmem[i] = 32'h000000A5;
        end
        t = 0;
        mp = 0; mwe = 0; maddr = '0; mwd = '0; s = 0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);

        // Table: read from port 0 with early drop and addr churn, port 1 write, port 1 read-back.
        tbl[0]  = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int c = 2; c <= 5; c++)
            tbl[c] = mk(0, 1, 32'h30 + 32'(c), 32'h77, 0, 0, 32'h0, 32'h0, 5'b10001, 32'h8, 32'h0, 32'h0, 32'h0);
        tbl[6]  = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'b00101, 32'h0, 32'h0, 32'hA5, 32'h0);
        tbl[7]  = mk(0, 0, 32'h0, 32'h0, 1, 1, 32'h4, 32'h3C, 5'b00000, 32'h0, 32'h0, 32'hA5, 32'h0);
        for (int c = 8; c <= 11; c++)
            tbl[c] = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'b01001, 32'h4, 32'h3C, 32'hA5, 32'h0);
        tbl[12] = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'b00011, 32'h0, 32'h0, 32'hA5, 32'h0);
        tbl[13] = mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'hDEAD, 5'b00000, 32'h0, 32'h0, 32'hA5, 32'h0);
        for (int c = 14; c <= 17; c++)
            tbl[c] = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'b10001, 32'h4, 32'hDEAD, 32'hA5, 32'h0);
        tbl[18] = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'b00011, 32'h0, 32'h0, 32'hA5, 32'h3C);
        tbl[19] = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'hA5, 32'h3C);

        @(negedge clk);
        do_reset();
        for (int k = 0; k < 20; k++) begin
            t = k;
            drive(tbl[k].r0, tbl[k].w0, tbl[k].a0, tbl[k].d0, tbl[k].r1, tbl[k].w1, tbl[k].a1, tbl[k].d1);
            chk("tbl_ctl", 64'(ctl_now()), 64'(tbl[k].ctl));
            chk("tbl_rdata0", 64'(bus.rdata0_o), 64'(tbl[k].q0));
            chk("tbl_rdata1", 64'(bus.rdata1_o), 64'(tbl[k].q1));
            if (tbl[k].ctl[4] | tbl[k].ctl[3]) begin
                chk("tbl_mem_addr", 64'(bus.mem_addr_o), 64'(tbl[k].ea));
                chk("tbl_mem_data", 64'(bus.mem_data_o), 64'(tbl[k].ed));
            end
            capture_write();
            @(negedge clk);
        end
        mmem[1] = 32'h3C;

        // Streaming from port 0, port 1 joins mid-access; then contention; then random traffic.
        t = 0;
        do_reset();
        model_init();
        run_model(2, 60, 10);
        run_model(1, 40, 0);
        run_model(0, 400, 0);
        run_model(3, 10, 0);

        // Reset during the second strobe cycle of a read.
        do_reset();
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rmid_strobe1", 64'(ctl_now()), 64'(5'b10001));
        chk("rmid_addr", 64'(bus.mem_addr_o), 64'h10);
        @(negedge clk);
        chk("rmid_strobe2", 64'(ctl_now()), 64'(5'b10001));
        #2 rst = 1'b1;
        #1 chk("rmid_async_clear", 64'(ctl_now()), 64'd0);
        chk("rmid_rdata0", 64'(bus.rdata0_o), 64'd0);
        drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        model_init();
        run_model(1, 30, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer for the shared single-port data memory.
- Port 0 is the CPU MEM stage and port 1 is the debug/loader port.
- Each grant becomes one read or write strobe held for a fixed LATENCY. Read data is captured and the winner receives a one-cycle ack.
- Sits between the requesters and the data memory; the memory strobes are driven only by this block.

Parameters:
- LATENCY, 4, cycles the memory strobe is held per access; legal range 1..15.
- ADDR_W, 32, byte-address width, passed through unchanged (memory indexes addr>>2).
- DATA_W, 32, data width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req0_i  in  1  port 0 request.
- we0_i  in  1  port 0: 1=write, 0=read.
- addr0_i  in  ADDR_W  port 0 byte address.
- wdata0_i  in  DATA_W  port 0 write data.
- rdata0_o  out  DATA_W  port 0 read data.
- ack0_o  out  1  port 0 completion pulse.
- req1_i, we1_i, addr1_i, wdata1_i, rdata1_o, ack1_o  as port 0, for port 1.
- busy_o  out  1  access in progress; high in BUSY and RESP.
- mem_addr_o  out  ADDR_W  memory address.
- mem_data_o  out  DATA_W  memory write data.
- mem_read_o  out  1  memory read strobe (MemRead).
- mem_write_o  out  1  memory write strobe (MemWrite).
- mem_data_i  in  DATA_W  memory read data.

Behaviour:
- Reset values (all asynchronous on rst_i):
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - Counter 0; all outputs 0, including rdata0/1, ack0/1, busy, mem_*.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If no req: stay in IDLE; mem_* outputs = 0.
  - If exactly one req: grant that port.
  - If both req: grant the port != last_grant.
  - On grant: latch winner's we/addr/wdata into internal registers, set last_grant=winner, cnt=LATENCY-1, go to BUSY.
- BUSY:
  - mem_addr_o/mem_data_o driven from the latched registers.
  - mem_read_o = ~we, mem_write_o = we; the two strobes are never both 1.
  - Strobe stays high for exactly LATENCY consecutive cycles.
  - Each cycle: if cnt==0, go to RESP (read: capture mem_data_i into the winner's rdata register on this edge); else cnt--.
- RESP:
  - Strobes low; ack of the winner = 1 for exactly this one cycle; next state IDLE.
- Timing: req sampled high at edge E0 -> strobe high for cycles E0+1..E0+LATENCY -> ack high in cycle E0+LATENCY+1.
- Next grant is decided at the edge ending the IDLE cycle after RESP. Minimum spacing between grants is LATENCY+2 cycles.
- rdataN_o holds its value until the next read completion on that port. Writes never change rdata.
- Requester inputs are ignored after grant. Deasserting req before ack does not abort: the access completes and ack still pulses.
- A requester holding req through ack and into the following IDLE cycle is treated as a new request.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. A single port requesting alone is granted back-to-back.
- Reset mid-BUSY: strobes drop asynchronously and no ack is issued. After release, arbitration restarts with port 0 priority.
- Address bits [1:0] pass through unchanged; no alignment check.
- LATENCY=1: one strobe cycle, then RESP.

Test Plan:
- Single read, LATENCY=4: mem_data_i=32'h000000A5, req0 read at addr 0x8 sampled at cycle 1 -> mem_read_o high cycles 2-5 with mem_addr_o=0x8; ack0 in cycle 6; rdata0_o=0xA5 from cycle 6 onward.
- Write then read: port 1 writes 0x3C to addr 0x4 -> mem_write_o high 4 cycles, mem_data_o=0x3C, mem_read_o stays 0, ack1 pulses once, rdata1 unchanged. A following read returns the value modelled by the bench memory.
- Contention: req0 and req1 both held high from reset release -> grant order 0,1,0,1. Acks spaced LATENCY+2 = 6 cycles apart; no cycle has ack0 and ack1 both high.
- Single-requester streaming: only req0 held high -> consecutive port 0 grants every 6 cycles; port 1 raised mid-access -> port 1 granted next.
- Early drop: req0 pulsed for one cycle with a read at addr 0x10 -> strobe still lasts 4 cycles and ack0 still pulses. Changing addr0_i during BUSY does not alter mem_addr_o.
- Reset mid-access: rst_i asserted in the 2nd strobe cycle -> mem_read_o, busy_o and acks are 0 immediately. After release with both requesting, port 0 is granted first.
